pipelined_barrel_shifter: RTL and testbench

//   Parametrised, fully pipelined barrel shifter for the execute path. It supports
//   SLL, SRL, SRA and (optionally) ROR on a WIDTH-bit operand.
//   - One shift stage per amount bit (1,2,4,...,WIDTH/2), each followed by a register.
//   - Valid/ready handshake on both sides; throughput of one op per cycle.
//   - A caller tag travels with each op so results can be matched to their source.

---
 rtl/pipelined_barrel_shifter.sv | 143 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Fully pipelined SLL/SRL/SRA(/ROR) barrel shifter. One register stage per
//   shift-amount bit, global stall on output backpressure, tag carried per op.
//   Build option: define SHIFT_ROTATE_EN to build the rotate-right wrap path
//   for op 2'b11; without it op 2'b11 behaves exactly like SRL.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  localparam logic [WIDTH-1:0] ONES = '1;

  // Index 0 is the accepted input; index k+1 is the register output of stage k.
  logic             stg_valid [0:AMT_W];
  logic [WIDTH-1:0] stg_data  [0:AMT_W];
  logic [TAG_W-1:0] stg_tag   [0:AMT_W];
  // Control only needs to reach the input of the last stage.
  logic [1:0]       stg_op    [0:AMT_W-1];
  logic [AMT_W-1:0] stg_amt   [0:AMT_W-1];
  logic             stg_sign  [0:AMT_W-1];

  logic adv;

  // The whole pipe moves together unless a held result blocks the output.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = in_data;
  assign stg_tag[0]   = in_tag;
  assign stg_op[0]    = in_op;
  assign stg_amt[0]   = in_amt;
  assign stg_sign[0]  = in_data[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < AMT_W; gi++) begin : g_stage
      localparam int SHIFT = 1 << gi;
      // MSB positions vacated by a right shift of SHIFT bits.
      localparam logic [WIDTH-1:0] FILL = ~(ONES >> SHIFT);

      logic             valid_d, valid_q;
      logic [WIDTH-1:0] data_d, data_q;
      logic [TAG_W-1:0] tag_d, tag_q;

      // Conditionally shift by 2^gi on advance, otherwise hold.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (adv) begin
          valid_d = stg_valid[gi];
          tag_d   = stg_tag[gi];
          data_d  = stg_data[gi];
          if (stg_amt[gi][gi]) begin
            case (stg_op[gi])
              OP_SLL:  data_d = stg_data[gi] << SHIFT;
              OP_SRA:  data_d = (stg_data[gi] >> SHIFT) | (stg_sign[gi] ? FILL : '0);
`ifdef SHIFT_ROTATE_EN
              OP_ROR:  data_d = (stg_data[gi] >> SHIFT) | (stg_data[gi] << (WIDTH - SHIFT));
`endif
              default: data_d = stg_data[gi] >> SHIFT;
            endcase
          end
        end
      end

      // Stage register; reset discards anything in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          tag_q   <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
          tag_q   <= tag_d;
        end
      end

      assign stg_valid[gi+1] = valid_q;
      assign stg_data[gi+1]  = data_q;
      assign stg_tag[gi+1]   = tag_q;

      if (gi < AMT_W - 1) begin : g_ctrl
        logic [1:0]       op_d, op_q;
        logic [AMT_W-1:0] amt_d, amt_q;
        logic             sign_d, sign_q;

        // Op, amount and sign follow the data so later stages see them.
        always_comb begin
          op_d   = op_q;
          amt_d  = amt_q;
          sign_d = sign_q;
          if (adv) begin
            op_d   = stg_op[gi];
            amt_d  = stg_amt[gi];
            sign_d = stg_sign[gi];
          end
        end

        // Control register beside the stage data.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            op_q   <= '0;
            amt_q  <= '0;
            sign_q <= 1'b0;
          end else begin
            op_q   <= op_d;
            amt_q  <= amt_d;
            sign_q <= sign_d;
          end
        end

        assign stg_op[gi+1]   = op_q;
        assign stg_amt[gi+1]  = amt_q;
        assign stg_sign[gi+1] = sign_q;
      end
    end
  endgenerate

  assign out_valid = stg_valid[AMT_W];
  assign out_data  = stg_data[AMT_W];
  assign out_tag   = stg_tag[AMT_W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter
//   Directed bench for the pipelined barrel shifter at WIDTH=16, TAG_W=4.
//   A scoreboard of expected results (computed arithmetically) is checked
//   every cycle a result transfers; directed vectors also carry literals.
module tb_pipelined_barrel_shifter;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [1:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int delivered = 0;
  int stall_cycles = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    bit            has_lit;
    logic [W-1:0]  lit;
    int            acc_cyc;
    bit            lat_chk;
  } exp_t;
  exp_t sb[$];

  bit           cur_has_lit = 0;
  logic [W-1:0] cur_lit = '0;
  bit           lat_chk = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the shift definitions.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt, input logic [1:0] op);
    logic [2*W-1:0] dd;
    case (op)
      2'b00:   return d << amt;
      2'b01:   return d >> amt;
      2'b10:   return W'($signed(d) >>> amt);
      default: begin
`ifdef SHIFT_ROTATE_EN
        dd = {d, d} >> amt;
        return dd[W-1:0];
`else
        dd = '0;
        return d >> amt;
`endif
      end
    endcase
  endfunction

  logic          held_pending = 0;
  logic [W-1:0]  held_data;
  logic [TW-1:0] held_tag;

  // Monitor: runs mid-cycle, checks handshake rule, holds and the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      held_pending = 0;
      check("valid_in_reset", {31'd0, out_valid}, 32'd0);
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (held_pending && out_valid) begin
        check("hold_data", {16'd0, out_data}, {16'd0, held_data});
        check("hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
      end
      held_pending = out_valid && !out_ready;
      held_data = out_data;
      held_tag = out_tag;
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_result: got data %h tag %h expected none", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          delivered++;
          $display("result tag=%h data=%h exp=%h", out_tag, out_data, e.data);
          check("out_data", {16'd0, out_data}, {16'd0, e.data});
          check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
          if (e.has_lit) check("literal", {16'd0, out_data}, {16'd0, e.lit});
          if (e.lat_chk) check("latency", cyc - e.acc_cyc, AW);
        end
      end
      if (in_valid && in_ready) begin
        e.data = model(in_data, int'(in_amt), in_op);
        e.tag = in_tag;
        e.has_lit = cur_has_lit;
        e.lit = cur_lit;
        e.acc_cyc = cyc;
        e.lat_chk = lat_chk;
        sb.push_back(e);
      end
    end
  end

  // Present one op and hold it until accepted; call at posedge+1.
  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] op,
                      input logic [TW-1:0] tag, input bit hl, input logic [W-1:0] lit);
    in_valid = 1; in_data = d; in_amt = a; in_op = op; in_tag = tag;
    cur_has_lit = hl; cur_lit = lit;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
    end
    n_cmp++; n_fail++;
    $display("FAIL send_timeout: in_ready stuck 0 expected 1");
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL drain_timeout: %0d pending expected 0", sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] ror_lit;
  int d0;

  initial begin
`ifdef SHIFT_ROTATE_EN
    ror_lit = 16'h4123;
`else
    ror_lit = 16'h0123;
`endif
    // Reset state.
    #2 rst = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 0;
    repeat (3) @(posedge clk);
    #1 check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Directed vectors, one at a time, latency checked.
    send(16'h8000, 4'd15, 2'b01, 4'd3, 1, 16'h0001); drain();
    send(16'h0001, 4'd15, 2'b00, 4'd4, 1, 16'h8000); drain();
    send(16'h8000, 4'd4,  2'b10, 4'd5, 1, 16'hF800); drain();
    send(16'h7FF0, 4'd4,  2'b10, 4'd6, 1, 16'h07FF); drain();
    send(16'hA5A5, 4'd0,  2'b10, 4'd7, 1, 16'hA5A5); drain();
    send(16'h1234, 4'd4,  2'b11, 4'd8, 1, ror_lit);  drain();
    send(16'hA5A5, 4'd0,  2'b11, 4'd9, 1, 16'hA5A5); drain();

    // Back-to-back sweep of every op and amount.
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 16; a++)
        send(16'hB3C5, 4'(a), 2'(op), 4'(a), 0, '0);
    drain();

    // Backpressure: 8 ops, consumer stalls 3 cycles at the first result.
    lat_chk = 0;
    d0 = delivered;
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'h9000 + 16'(i * 16'h0111), 4'(i + 1), 2'(i % 4), 4'(i), 0, '0);
      end
      begin
        for (int t = 0; t < 50 && !out_valid; t++) begin
          @(posedge clk); #1;
        end
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("bp_delivered", delivered - d0, 8);
    check("bp_stall_cycles", stall_cycles, 3);

    // Reset with three ops in flight.
    send(16'h00F0, 4'd1, 2'b00, 4'd1, 0, '0);
    send(16'h00F0, 4'd2, 2'b01, 4'd2, 0, '0);
    send(16'h00F0, 4'd3, 2'b10, 4'd3, 0, '0);
    rst = 1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Recovery after reset.
    lat_chk = 1;
    @(posedge clk); #1;
    send(16'h0003, 4'd2, 2'b00, 4'd10, 1, 16'h000C); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
